// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: the default
// operand width and the sequencer state encoding.
package serial_arith_pkg;

    // Default operand/result width in bits (legal range 2..32).
    localparam int WIDTH_DEFAULT = 8;

    // Sequencer states. The encoding is fixed so that the debug state
    // output can be decoded by external checkers without this package.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor_1bit.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
// Purely combinational; the borrow flop lives in the serial datapath.
module full_subtractor_1bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow out for a single bit position
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b (mod 2^WIDTH) one bit per clock,
// LSB first, and reports the final borrow.
//
// Handshake: start is sampled only in IDLE. An accepted start latches a/b
// and busy is high for exactly WIDTH cycles while bits are processed; done
// then pulses for one cycle with diff/borrow already updated, and the block
// returns to IDLE on the following edge. start seen in RUN or DONE is
// ignored. A continuously held start therefore yields one result every
// WIDTH+2 cycles. diff/borrow only change at a completion (or reset).
//
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the ovf output
// (signed two's-complement overflow of the subtraction).
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output state_t           dbg_state
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Bit counter only needs to reach WIDTH-1.
    localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 result bits produced so far; the last bit goes
    // straight from the full subtractor into diff at completion.
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic             bin_q;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_bit;
    logic             d_bit;
    logic             bout_bit;

    assign accept   = (state == IDLE) && start;
    assign last_bit = (state == RUN) && (cnt == CNT_LAST);
    assign res_nxt  = {d_bit, res_sr};

    assign dbg_state = state;

    full_subtractor_1bit u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last bit,
    // DONE always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Serial datapath: load operands on accept, then shift one bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            bin_q  <= 1'b0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= res_nxt[WIDTH-1:1];
            bin_q  <= bout_bit;
            cnt    <= cnt + 1'b1;
        end
    end

    // Result registers: updated only on the final bit so a partial result
    // never becomes visible
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff   <= '0;
            borrow <= 1'b0;
        end else if (last_bit) begin
            diff   <= res_nxt;
            borrow <= bout_bit;
        end
    end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are shifted out during RUN, so keep copies
    logic a_msb;
    logic b_msb;

    // Capture operand signs on accept and compute overflow at completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (last_bit) begin
            ovf   <= (a_msb != b_msb) && (d_bit != a_msb);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): reset values, a table
// of directed vectors with latency/busy/stability checks, start ignored in
// RUN and DONE, reset in mid-operation, and 100 random back-to-back
// operations with start held high. Expected results come from a queue fed
// by the vector table or by an arithmetic reference model.
module tb_serial_subtractor;
    import serial_arith_pkg::*;

    localparam int WIDTH = 8;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    state_t           dbg_state;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;
`endif

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .diff      (diff),
        .borrow    (borrow),
        .dbg_state (dbg_state)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Watchdog: the run is a few thousand cycles at most
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int               checks = 0;
    int               errors = 0;
    logic [WIDTH:0]   exp_q[$];      // {borrow, diff}
    logic             exp_ovf_q[$];
    logic [WIDTH:0]   last_res;      // model of the held {borrow, diff}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: unsigned subtraction with one extra bit for the borrow
    function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        return {1'b0, x} - {1'b0, y};
    endfunction

    // Reference: signed result out of the representable range
    function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        longint half = longint'(1) << (WIDTH - 1);
        longint sx   = (longint'(x) >= half) ? longint'(x) - 2 * half : longint'(x);
        longint sy   = (longint'(y) >= half) ? longint'(y) - 2 * half : longint'(y);
        longint r    = sx - sy;
        return (r > half - 1) || (r < -half);
    endfunction

    task automatic push_exp(input logic [WIDTH:0] res, input logic ov);
        exp_q.push_back(res);
        exp_ovf_q.push_back(ov);
    endtask

    task automatic check_result(input string name);
        logic [WIDTH:0] e;
        logic           eo;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: result with empty expected queue, got 0x%0h", name, {borrow, diff});
        end else begin
            e  = exp_q.pop_front();
            eo = exp_ovf_q.pop_front();
            check({name, "_result"}, {borrow, diff}, e);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            check({name, "_ovf"}, ovf, eo);
`endif
            last_res = e;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Present operands with start for one edge; returns on the negedge after
    // the accepting edge.
    task automatic drive_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follow an operation from the negedge after its accepting edge to
    // completion. inject_run >= 0 raises start (with a different a) during
    // that RUN cycle; inject_done raises start during the DONE cycle.
    task automatic finish_op(input string name, input int inject_run, input bit inject_done);
        int lat    = 0;
        int n_busy = 0;
        bit stable = 1'b1;
        while (!done && lat < WIDTH + 4) begin
            if (busy) n_busy++;
            if ({borrow, diff} !== last_res) stable = 1'b0;
            if (lat == inject_run) begin
                a     = 8'h10;
                start = 1'b1;
            end
            if (lat == inject_run + 1) start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({name, "_done"}, done, 1'b1);
        check({name, "_latency"}, lat, WIDTH);
        check({name, "_busy_cycles"}, n_busy, WIDTH);
        check({name, "_stable_in_run"}, stable, 1'b1);
        check({name, "_busy_at_done"}, busy, 1'b0);
        check_result(name);
        if (inject_done) begin
            a     = 8'h33;
            b     = 8'h11;
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        check({name, "_done_one_cycle"}, done, 1'b0);
        if (inject_done) begin
            @(negedge clk);
            check({name, "_no_relatch"}, busy, 1'b0);
            check({name, "_held_result"}, {borrow, diff}, last_res);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] diff;
        logic             borrow;
        logic             ovf;
    } vec_t;

    vec_t vecs[9];

    // ---------------- main sequence ----------------
    initial begin
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        int               c;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
        vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
        vecs[8] = '{8'h01, 8'h02, 8'hFF, 1'b1, 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        last_res = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_diff", diff, 8'h00);
        check("reset_borrow", borrow, 1'b0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("reset_ovf", ovf, 1'b0);
`endif
        rst = 1'b0;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            push_exp({vecs[i].borrow, vecs[i].diff}, vecs[i].ovf);
            drive_start(vecs[i].a, vecs[i].b);
            finish_op($sformatf("vec%0d", i), -1, 1'b0);
        end

        // start with a different a while RUN is ignored
        push_exp({1'b0, 8'h05}, 1'b0);
        drive_start(8'h09, 8'h04);
        finish_op("ignore_in_run", 3, 1'b0);

        // start during DONE is ignored as well
        push_exp({1'b1, 8'hF0}, 1'b0);
        drive_start(8'h10, 8'h20);
        finish_op("ignore_in_done", -1, 1'b1);

        // Reset in the 4th RUN cycle: outputs clear at once, no done follows
        drive_start(8'h05, 8'h03);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_busy", busy, 1'b0);
        check("midrun_rst_done", done, 1'b0);
        check("midrun_rst_diff", diff, 8'h00);
        check("midrun_rst_borrow", borrow, 1'b0);
        last_res = '0;
        @(negedge clk);
        rst   = 1'b0;
        a     = 8'h20;
        b     = 8'h01;
        start = 1'b1;
        push_exp({1'b0, 8'h1F}, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("start_after_rst_busy", busy, 1'b1);
        finish_op("after_rst", -1, 1'b0);

        // Start held high: back-to-back random operations
        @(negedge clk);
        x     = WIDTH'($urandom_range(0, 2 ** WIDTH - 1));
        y     = WIDTH'($urandom_range(0, 2 ** WIDTH - 1));
        a     = x;
        b     = y;
        start = 1'b1;
        push_exp(ref_sub(x, y), ref_ovf(x, y));
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            c = 1;
            while (!done && c < 3 * WIDTH) begin
                @(negedge clk);
                c++;
            end
            check($sformatf("held%0d_done", i), done, 1'b1);
            check($sformatf("held%0d_period", i), c, (i == 0) ? WIDTH + 1 : WIDTH + 2);
            check_result($sformatf("held%0d", i));
            if (i < 99) begin
                x = WIDTH'($urandom_range(0, 2 ** WIDTH - 1));
                y = WIDTH'($urandom_range(0, 2 ** WIDTH - 1));
                a = x;
                b = y;
                push_exp(ref_sub(x, y), ref_ovf(x, y));
            end else begin
                start = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
        check("final_idle_busy", busy, 1'b0);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 SHALL have port rst  input  1  the reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  the request to begin a subtraction.
REQ-005 SHALL have port a  input  WIDTH  the minuend, sampled only on an accepted start.
REQ-006 SHALL have port b  input  WIDTH  the subtrahend, sampled only on an accepted start.
REQ-007 SHALL have port busy  output  1  high while bits are being processed.
REQ-008 SHALL have port done  output  1  a one-cycle completion pulse.
REQ-009 SHALL have port diff  output  WIDTH  the result a-b modulo 2^WIDTH.
REQ-010 SHALL have port borrow  output  1  the final borrow out (high when a < b unsigned).

Function
REQ-011 SHALL implement FSM states IDLE, RUN and DONE.
REQ-012 SHALL accept start only in IDLE; an accepted start at edge E0 latches a and b into shift registers, clears the internal borrow and bit counter, and enters RUN.
REQ-013 SHALL process one bit per edge in RUN, LSB first: d = a0^b0^bin; bout = (~a0&b0) | (~(a0^b0)&bin).
REQ-014 SHALL, at edges E1..EWIDTH, shift the operands right and shift d into the MSB of an internal result register.
REQ-015 SHALL, at edge EWIDTH, copy the complete result to diff, copy the final bout to borrow, and enter DONE.
REQ-016 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE on the next edge; total latency is WIDTH cycles from the start edge to done high.
REQ-017 SHALL assert busy exactly while in RUN.
REQ-018 SHALL ignore start while in RUN or DONE; no re-latch occurs and no error is flagged.
REQ-019 SHALL hold diff and borrow stable from completion until the next completion; they SHALL NOT change during RUN.
REQ-020 SHALL treat a held start as a new request on the first IDLE cycle, giving back-to-back operations every WIDTH+2 cycles.

Reset
REQ-021 SHALL, on rst high, immediately force state IDLE, busy=0, done=0, diff=0, borrow=0 and clear all internal registers, regardless of clock.
REQ-022 SHALL abort any in-progress operation on reset mid-RUN; the partial result SHALL NOT reach diff.
REQ-023 SHALL accept start on the first edge after rst deasserts.

Configuration
REQ-024 SHALL, when macro SERIAL_SUBTRACTOR_OVF_EN is defined, add port ovf  output  1  signed two's-complement overflow, updated with diff at completion: ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]); reset value 0.
REQ-025 SHALL, without SERIAL_SUBTRACTOR_OVF_EN, have no ovf port or related logic; all other behaviour is identical.

Structure
REQ-026 SHALL place FSM state encodings (IDLE=0, RUN=1, DONE=2) and the WIDTH default constant in shared package serial_arith_pkg.
REQ-027 SHALL instantiate one combinational sub-module full_subtractor_1bit (ports a, b, bin, d, bout) for the per-bit arithmetic; the borrow flop lives in serial_subtractor.

Verification (WIDTH=8)
REQ-028 SHALL verify: a=0x05, b=0x03, start pulse -> done 8 cycles later, diff=0x02, borrow=0, busy high for 8 cycles.
REQ-029 SHALL verify: a=0x03, b=0x05 -> diff=0xFE, borrow=1; and a=0x80, b=0x01 -> diff=0x7F, borrow=0, ovf=1 (macro defined).
REQ-030 SHALL verify: start with a=0x10 while busy after a=0x09, b=0x04 -> ignored, result diff=0x05, borrow=0.
REQ-031 SHALL verify: rst pulse at cycle 4 of RUN -> busy=0, done=0, diff=0x00, borrow=0 immediately; no done pulse follows.
REQ-032 SHALL verify: start held high continuously -> done pulses every 10 cycles; 100 random a/b pairs each match {borrow,diff} = {1'b0,a} - {1'b0,b}.
